// File: rtl/aes128_round_controller.sv
// Iterative AES-128 encryption controller: one full cipher round per clock with
// an on-the-fly key schedule, valid/ready handshakes on both the block input and the ciphertext output.
module aes128_round_controller #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] plaintext,
  input  logic [0:127] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] ciphertext,
  output logic         busy,
  output logic [3:0]   round_num
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Internal 128-bit words keep byte 0 in bits [127:120]; byte i of column c is index 4*c+row.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++)
      o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {rk[23:0], rk[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64]  ^ w0;
    w2 = rk[63:32]  ^ w1;
    w3 = rk[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t       r_fsm, w_fsm_next;
  logic [127:0] r_state, r_rk, r_ct;
  logic [3:0]   r_round;
  logic         r_out_valid;
  logic         w_accept, w_last;
  logic [127:0] w_sr, w_rk_next, w_round_out;

  always_ff @(posedge clk) begin
    if (reset) r_fsm <= IDLE;
    else       r_fsm <= w_fsm_next;
  end

  always_comb begin
    w_fsm_next = r_fsm;
    in_ready   = 1'b0;
    busy       = 1'b0;
    w_last     = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_next = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        w_last = (r_round == LAST);
        if (w_last) w_fsm_next = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) w_fsm_next = in_valid ? RUN : IDLE;
      end
      default: w_fsm_next = IDLE;
    endcase
  end

  assign w_accept    = in_valid && in_ready;
  assign w_sr        = shift_rows(sub_bytes(r_state));
  assign w_rk_next   = expand(r_rk, rcon(r_round));
  assign w_round_out = (w_last ? w_sr : mix_columns(w_sr)) ^ w_rk_next;

  // Accept and RUN are mutually exclusive, so the load branch never masks a round.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= '0;
      r_rk        <= '0;
      r_ct        <= '0;
      r_round     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_state <= plaintext ^ key;
        r_rk    <= key;
        r_round <= 4'd1;
      end else if (r_fsm == RUN) begin
        r_state <= w_round_out;
        r_rk    <= w_rk_next;
        r_round <= w_last ? 4'd0 : r_round + 4'd1;
        if (w_last) r_ct <= w_round_out;
      end
      if (w_last)                         r_out_valid <= 1'b1;
      else if (r_fsm == DONE && out_ready) r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign ciphertext = r_ct;
  assign round_num  = r_round;

endmodule

// File: tb/tb_aes128_round_controller.sv
// Self-checking bench for aes128_round_controller: expected ciphertexts are queued
// when a block is accepted and compared by a monitor when the output handshake completes.
module tb_aes128_round_controller;
  localparam int unsigned NR = 10;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] S0  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] RK1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] RKN = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [0:127] plaintext, key, ciphertext;
  logic [3:0]   round_num;

  int           errors = 0;
  int           checks = 0;
  logic [127:0] exp_q[$];
  logic [127:0] mon_exp;

  always #5 clk = ~clk;

  aes128_round_controller #(.NR(NR)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy),
    .round_num  (round_num)
  );

  // Scoreboard consumer: one comparison per completed output handshake.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected_output got=%h", ciphertext);
      end else begin
        mon_exp = exp_q.pop_front();
        if (ciphertext !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard_ciphertext got=%h exp=%h", ciphertext, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a block and wait for it to be taken; leaves in_valid asserted.
  task automatic start_block(input logic [127:0] p, input logic [127:0] k, input logic [127:0] c);
    bit ok = 0;
    plaintext = p;
    key       = k;
    in_valid  = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(c);
        ok = 1;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b exp=1", in_ready);
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int i = 0; i < 40 && out_valid !== 1'b1; i++) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_valid_timeout out_valid=%b exp=1", out_valid);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d exp=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    plaintext = '0; key = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks += 7;
    if (in_ready !== 1'b1)     begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0)    begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (round_num !== 4'd0)    begin errors++; $display("FAIL reset_round_num got=%0d exp=0", round_num); end
    if (ciphertext !== '0)     begin errors++; $display("FAIL reset_ciphertext got=%h exp=0", ciphertext); end
    if (dut.r_state !== '0)    begin errors++; $display("FAIL reset_state got=%h exp=0", dut.r_state); end
    if (dut.r_rk !== '0)       begin errors++; $display("FAIL reset_rk got=%h exp=0", dut.r_rk); end
  endtask

  task automatic test_fips();
    out_ready = 1'b1;
    start_block(P1, K1, C1);
    in_valid = 1'b0;
    checks += 3;
    if (dut.r_state !== S0) begin errors++; $display("FAIL round0_state got=%h exp=%h", dut.r_state, S0); end
    if (round_num !== 4'd1) begin errors++; $display("FAIL round0_round_num got=%0d exp=1", round_num); end
    if (busy !== 1'b1)      begin errors++; $display("FAIL round0_busy got=%b exp=1", busy); end
    // Accept edge counts as cycle 1, so out_valid must appear on edge NR+1.
    for (int j = 1; j <= NR; j++) begin
      tick();
      checks += 2;
      if (round_num !== ((j < NR) ? 4'(j + 1) : 4'd0)) begin
        errors++; $display("FAIL round_num_step%0d got=%0d exp=%0d", j, round_num, (j < NR) ? j + 1 : 0);
      end
      if (out_valid !== (j == NR)) begin
        errors++; $display("FAIL latency_edge%0d out_valid=%b exp=%b", j + 1, out_valid, j == NR);
      end
      if (j == 1) begin
        checks++;
        if (dut.r_rk !== RK1) begin errors++; $display("FAIL round1_rk got=%h exp=%h", dut.r_rk, RK1); end
      end
      if (j == NR) begin
        checks += 2;
        if (dut.r_rk !== RKN)   begin errors++; $display("FAIL round10_rk got=%h exp=%h", dut.r_rk, RKN); end
        if (ciphertext !== C1)  begin errors++; $display("FAIL fips_ciphertext got=%h exp=%h", ciphertext, C1); end
      end
    end
    tick();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL fips_release_out_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL fips_idle_in_ready got=%b exp=1", in_ready); end
    check_drained("fips");
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    start_block(P1, K1, C1);
    in_valid = 1'b0;
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      plaintext = P2; key = K2; in_valid = 1'b1;
      @(negedge clk);
      checks += 4;
      if (in_ready !== 1'b0)   begin errors++; $display("FAIL bp_in_ready_c%0d got=%b exp=0", i, in_ready); end
      if (out_valid !== 1'b1)  begin errors++; $display("FAIL bp_out_valid_c%0d got=%b exp=1", i, out_valid); end
      if (ciphertext !== C1)   begin errors++; $display("FAIL bp_hold_c%0d got=%h exp=%h", i, ciphertext, C1); end
      if (busy !== 1'b0)       begin errors++; $display("FAIL bp_busy_c%0d got=%b exp=0", i, busy); end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready);
    end else begin
      exp_q.push_back(C2);
    end
    tick();
    in_valid = 1'b0;
    checks += 3;
    if (busy !== 1'b1)      begin errors++; $display("FAIL bp_reload_busy got=%b exp=1", busy); end
    if (round_num !== 4'd1) begin errors++; $display("FAIL bp_reload_round got=%0d exp=1", round_num); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_reload_out_valid got=%b exp=0", out_valid); end
    wait_out(n);
    tick();
    check_drained("backpressure");
  endtask

  task automatic test_back_to_back();
    int  gap = 0;
    int  n;
    bit  ok  = 0;
    out_ready = 1'b1;
    start_block(P1, K1, C1);
    plaintext = P2; key = K2;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(C2);
        ok  = 1;
        gap = i + 1;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (gap != NR + 1) begin errors++; $display("FAIL b2b_accept_spacing got=%0d exp=%0d", gap, NR + 1); end
    wait_out(n);
    checks++;
    if (n != NR) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=%0d", n, NR); end
    tick();
    check_drained("back_to_back");
  endtask

  task automatic test_input_stability();
    out_ready = 1'b1;
    start_block(P1, K1, C1);
    for (int j = 1; j <= NR; j++) begin
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      in_valid  = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stab_in_ready_r%0d got=%b exp=0", j, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL stab_out_valid got=%b exp=1", out_valid); end
    tick();
    check_drained("stability");
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    out_ready = 1'b1;
    start_block(P1, K1, C1);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && round_num !== 4'd5; i++) tick();
    checks++;
    if (round_num !== 4'd5) begin errors++; $display("FAIL rst_reach_round5 got=%0d exp=5", round_num); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    checks += 6;
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    if (round_num !== 4'd0)  begin errors++; $display("FAIL rst_mid_round got=%0d exp=0", round_num); end
    if (ciphertext !== '0)   begin errors++; $display("FAIL rst_mid_ciphertext got=%h exp=0", ciphertext); end
    if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
    if (dut.r_rk !== '0)     begin errors++; $display("FAIL rst_mid_rk got=%h exp=0", dut.r_rk); end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL rst_mid_no_output got=%0d exp=0", pulses); end
    test_fips();
  endtask

  initial begin
    test_reset();
    test_fips();
    test_backpressure();
    test_back_to_back();
    test_input_stability();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes128_round_controller.md
Name: aes128_round_controller

Overview:
- Iterative AES-128 encryption engine controller. Sequences one full cipher round per clock over the team's existing combinational round stages (sub_bytes, shift_rows, mix_columns, add_round_key), with an on-the-fly key schedule.
- Accepts a plaintext/key pair over a valid/ready handshake and returns ciphertext over a second valid/ready handshake.
- Sits between the system bus wrapper and the AES datapath; it is the only block that drives the round datapath.

Parameters:
- NR, 10, number of cipher rounds. 10 = AES-128. Values 1..10 are permitted only for reduced-round debug. The final round always omits mix_columns.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  plaintext/key offered
- in_ready  output  1  controller can accept a block this cycle
- plaintext  input  [0:127]  input block, bit 0 = MSB of byte 0
- key  input  [0:127]  cipher key, same byte order
- out_valid  output  1  ciphertext available
- out_ready  input  1  consumer takes ciphertext
- ciphertext  output  [0:127]  result, registered
- busy  output  1  high in RUN
- round_num  output  [3:0]  current round index, 0 when not in RUN

Behaviour:
- Reset values: FSM = IDLE; in_ready = 1; out_valid = 0; busy = 0; round_num = 0; ciphertext = 0; internal state and round-key registers = 0.
- FSM states: IDLE, RUN, DONE.
- in_ready = (FSM == IDLE) || (FSM == DONE && out_ready). It is combinational from FSM state and out_ready.
- Accept (in_valid && in_ready), at edge E0:
  - state_reg <= plaintext ^ key (round 0 add_round_key).
  - rk_reg <= key.
  - round_num <= 1.
  - FSM -> RUN.
- RUN, round r (1..NR), one per edge:
  - rk_next = expand(rk_reg, rcon[r]), with rcon = 01,02,04,08,10,20,40,80,1b,36.
  - expand: w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,00,00,00}; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - r < NR: state_reg <= add_round_key(mix_columns(shift_rows(sub_bytes(state_reg))), rk_next).
  - r == NR: state_reg <= add_round_key(shift_rows(sub_bytes(state_reg)), rk_next).
  - rk_reg <= rk_next; round_num <= r + 1.
  - At r == NR: ciphertext <= final result; out_valid <= 1; round_num <= 0; FSM -> DONE.
- Latency: out_valid rises NR+1 cycles after the accept edge (11 for AES-128). Throughput: one block per NR+1 cycles when out_ready is held high.
- DONE:
  - ciphertext and out_valid are held stable until out_ready = 1.
  - On out_ready with no accept: out_valid <= 0, FSM -> IDLE.
  - On out_ready with a simultaneous accept: out_valid <= 0 and a new block is loaded in the same edge (FSM -> RUN).
- in_valid during RUN is ignored (in_ready = 0). plaintext and key are sampled only on the accept edge; later changes have no effect.
- reset asserted in any state, including mid-RUN or DONE with unconsumed output, returns every register to its reset value on the next edge. The in-flight block is discarded and no out_valid is produced.
- ciphertext changes only on the NR-th round edge or on reset.

Test Plan:
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, plaintext=00112233445566778899aabbccddeeff, out_ready=1 -> out_valid exactly 11 cycles after accept; ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a.
- Internal round checks for the same vector:
  - after the accept edge, state_reg=00102030405060708090a0b0c0d0e0f0;
  - after round 1, rk_reg=d6aa74fdd2af72fadaa678f1d6ab76fe;
  - after round 10, rk_reg=13111d7fe3944a17f307a78b4d2b30c5;
  - round_num steps 1..10, then 0.
- Back-pressure: out_ready=0 for 5 cycles after completion -> out_valid and ciphertext held; in_ready=0; a second in_valid is not accepted. Raising out_ready with in_valid=1 -> the new block is accepted on the same edge.
- Back-to-back: FIPS-197 vector, then key=2b7e151628aed2a6abf7158809cf4f3c with plaintext=3243f6a8885a308d313198a2e0370734, in_valid and out_ready held high -> ciphertexts 69c4e0d8... then 3925841d02dc09fbdc118597196a0b32, spaced 11 cycles apart.
- Input stability: toggle plaintext and key every cycle during RUN -> result unchanged (69c4e0d8...); in_ready stays 0 throughout RUN.
- Reset mid-operation: assert reset at round 5 for 1 cycle -> next cycle FSM=IDLE, out_valid=0, busy=0, round_num=0, ciphertext=0; no out_valid pulse follows. A subsequent FIPS vector completes correctly.
